// File: rtl/hsv_core_flush_sequencer.sv
// Flush sequencer: broadcasts a pipeline flush, waits for drain (or timeout),
// issues one PC redirect to fetch, then holds ack until the request is released.
module hsv_core_flush_sequencer #(
  parameter int NUM_STAGES       = 4,
  parameter int MIN_DRAIN_CYCLES = 1,
  parameter int TIMEOUT_CYCLES   = 256
) (
  input  logic                  clk_core,
  input  logic                  rst_core_n,
  input  logic                  flush_req,
  input  logic [31:0]           flush_target,
  output logic                  flush_ack,
  output logic [NUM_STAGES-1:0] stage_flush,
  input  logic [NUM_STAGES-1:0] stage_idle,
  output logic                  fetch_redirect_valid,
  input  logic                  fetch_redirect_ready,
  output logic [31:0]           fetch_redirect_pc,
  output logic                  flush_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] MIN_C = CW'(MIN_DRAIN_CYCLES);
  localparam logic [CW-1:0] TO_C  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_REDIRECT,
    ST_ACK
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CW-1:0]           r_drain_cnt;
  logic [CW-1:0]           w_cnt_nxt;
  logic                    w_timeout_set;
  logic                    w_latch_pc;
  logic                    w_all_idle;
  logic [NUM_STAGES-1:0]   r_stage_flush;
  logic                    r_valid;
  logic                    r_ack;
  logic [31:0]             r_pc;
  logic                    r_timeout;

  assign w_all_idle = &stage_idle;
  // The counter reads 1 only on the first DRAIN cycle, which is when the target is valid.
  assign w_latch_pc = (r_state == ST_DRAIN) && (r_drain_cnt == ONE_C);

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_timeout_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (flush_req) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((r_drain_cnt >= MIN_C) && w_all_idle) begin
          w_state_nxt = ST_REDIRECT;
        end else if (r_drain_cnt == TO_C) begin
          w_state_nxt   = ST_REDIRECT;
          w_timeout_set = 1'b1;
        end
      end
      ST_REDIRECT: begin
        if (fetch_redirect_ready) w_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        if (!flush_req) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_drain_cnt;
    if (w_state_nxt == ST_IDLE) begin
      w_cnt_nxt = '0;
    end else if (r_state == ST_IDLE) begin
      w_cnt_nxt = ONE_C;
    end else if ((r_state == ST_DRAIN) && (r_drain_cnt != TO_C)) begin
      w_cnt_nxt = r_drain_cnt + ONE_C;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_state       <= ST_IDLE;
      r_drain_cnt   <= '0;
      r_stage_flush <= '0;
      r_valid       <= 1'b0;
      r_ack         <= 1'b0;
      r_pc          <= '0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_drain_cnt   <= w_cnt_nxt;
      // Outputs decode the next state so they are registered yet track the state exactly.
      r_stage_flush <= {NUM_STAGES{w_state_nxt != ST_IDLE}};
      r_valid       <= (w_state_nxt == ST_REDIRECT);
      r_ack         <= (w_state_nxt == ST_ACK);
      if (w_latch_pc)    r_pc      <= flush_target;
      if (w_timeout_set) r_timeout <= 1'b1;
    end
  end

  assign stage_flush          = r_stage_flush;
  assign fetch_redirect_valid = r_valid;
  assign fetch_redirect_pc    = r_pc;
  assign flush_ack            = r_ack;
  assign flush_timeout        = r_timeout;

endmodule

// File: tb/tb_hsv_core_flush_sequencer.sv
// Bench for hsv_core_flush_sequencer: each flush is planned up front and the expected
// waveform is derived from the plan's event times (drain exit, handshake, release).
module tb_hsv_core_flush_sequencer;

  localparam int NS  = 4;
  localparam int MIN = 1;
  localparam int TO  = 16;

  logic          clk_core = 1'b0;
  logic          rst_core_n;
  logic          flush_req;
  logic [31:0]   flush_target;
  logic          flush_ack;
  logic [NS-1:0] stage_flush;
  logic [NS-1:0] stage_idle;
  logic          fetch_redirect_valid;
  logic          fetch_redirect_ready;
  logic [31:0]   fetch_redirect_pc;
  logic          flush_timeout;

  int   checks = 0;
  int   errors = 0;
  logic sticky_to = 1'b0;

  hsv_core_flush_sequencer #(
    .NUM_STAGES      (NS),
    .MIN_DRAIN_CYCLES(MIN),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk_core            (clk_core),
    .rst_core_n          (rst_core_n),
    .flush_req           (flush_req),
    .flush_target        (flush_target),
    .flush_ack           (flush_ack),
    .stage_flush         (stage_flush),
    .stage_idle          (stage_idle),
    .fetch_redirect_valid(fetch_redirect_valid),
    .fetch_redirect_ready(fetch_redirect_ready),
    .fetch_redirect_pc   (fetch_redirect_pc),
    .flush_timeout       (flush_timeout)
  );

  always #5 clk_core = ~clk_core;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sf"},    32'(stage_flush), 32'h0);
    check({tag, "_valid"}, 32'(fetch_redirect_valid), 32'h0);
    check({tag, "_ack"},   32'(flush_ack), 32'h0);
    check({tag, "_pc"},    fetch_redirect_pc, 32'h0);
    check({tag, "_to"},    32'(flush_timeout), 32'h0);
  endtask

  // Called in an IDLE cycle ("cycle 0"). Stage i reports idle from cycle d_i on
  // (>= 1000 means never), fetch stalls rdy_dly cycles, flush_req is high for hold cycles.
  task automatic run_flush(input logic [31:0] tgt, input int d0, input int d1, input int d2,
                           input int d3, input int rdy_dly, input int hold);
    int d[NS];
    int need, e, h, a, hs;
    bit timed;
    d = '{d0, d1, d2, d3};
    need = MIN;
    for (int i = 0; i < NS; i++) if (d[i] > need) need = d[i];
    timed = (need > TO);
    e = timed ? TO : need;          // last DRAIN cycle
    h = e + 1 + rdy_dly;            // handshake cycle
    a = (hold > h + 1) ? hold : h + 1;  // last ACK cycle
    hs = 0;
    for (int n = 0; n <= a + 1; n++) begin
      if (n > 0) begin
        tick();
        check($sformatf("stage_flush@%0d", n), 32'(stage_flush), (n <= a) ? 32'hF : 32'h0);
        check($sformatf("valid@%0d", n), 32'(fetch_redirect_valid), 32'(n >= e + 1 && n <= h));
        check($sformatf("ack@%0d", n), 32'(flush_ack), 32'(n >= h + 1 && n <= a));
        check($sformatf("timeout@%0d", n), 32'(flush_timeout),
              32'(sticky_to | (timed && n >= e + 1)));
        if (n >= e + 1 && n <= h) check($sformatf("pc@%0d", n), fetch_redirect_pc, tgt);
      end
      flush_req    = (n < hold);
      flush_target = (n == 1) ? tgt : $urandom;
      if (n >= 1 && n <= e) begin
        for (int i = 0; i < NS; i++) stage_idle[i] = (n >= d[i]);
      end else begin
        stage_idle = NS'($urandom);
      end
      if (n >= e + 1 && n <= h) fetch_redirect_ready = (n == h);
      else                      fetch_redirect_ready = 1'($urandom_range(0, 1));
      #1;
      if (n > 0 && fetch_redirect_valid && fetch_redirect_ready) hs++;
    end
    check("redirect_count", 32'(hs), 32'h1);
    check("pc_after_flush", fetch_redirect_pc, tgt);
    if (timed) sticky_to = 1'b1;
  endtask

  initial begin
    rst_core_n           = 1'b0;
    flush_req            = 1'b1;
    flush_target         = 32'h0;
    stage_idle           = '1;
    fetch_redirect_ready = 1'b1;
    #2;
    check_all_zero("reset");
    tick();
    tick();
    check_all_zero("reset_held");
    rst_core_n = 1'b1;

    // Flush asserted out of reset, minimum latency, target 0.
    run_flush(32'h0000_0000, 0, 0, 0, 0, 0, 4);
    // Stages drain one at a time; target changes during DRAIN must not matter.
    run_flush(32'h8000_0100, 2, 3, 4, 5, 0, 8);
    // Fetch stalls 7 cycles.
    run_flush($urandom, 0, 0, 0, 0, 7, 12);
    // One stage never drains: timeout at cycle 16, redirect still issued.
    run_flush($urandom, 0, 0, 0, 1000, 0, 20);
    // Wait-for-interrupt: request held ~100 cycles past ack.
    run_flush($urandom, 1, 0, 0, 0, 0, 105);
    // Immediate re-request after release.
    run_flush(32'h0000_0040, 0, 0, 0, 0, 1, 5);
    // Early release: single-cycle ack pulse.
    run_flush($urandom, 3, 3, 3, 3, 2, 2);
    run_flush($urandom, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++) begin
      run_flush($urandom, $urandom_range(0, 20), $urandom_range(0, 20),
                $urandom_range(0, 20), $urandom_range(0, 20),
                $urandom_range(0, 6), $urandom_range(1, 30));
    end

    // Reset while draining.
    flush_req    = 1'b1;
    flush_target = $urandom;
    stage_idle   = 4'h7;
    tick();
    flush_target = 32'hDEAD_BEEF;
    tick();
    tick();
    check("drain_sf", 32'(stage_flush), 32'hF);
    check("drain_valid", 32'(fetch_redirect_valid), 32'h0);
    #3;
    rst_core_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    sticky_to = 1'b0;
    tick();
    check_all_zero("mid_reset_held");
    rst_core_n = 1'b1;
    run_flush(32'h1234_5678, 0, 0, 0, 0, 0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
